// File: rtl/rr_sel_arbiter_4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_sel_arbiter_4_pkg
//  Purpose  : Shared constants for the 4-requester round-robin select arbiter
//  Revision : 1.0 - initial release
// ============================================================================
package rr_sel_arbiter_4_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   // Two-state arbiter FSM encoding
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_GRANT = 1'b1;

endpackage : rr_sel_arbiter_4_pkg
`default_nettype wire

// File: rtl/rr_sel_arbiter_4_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick_4
//  Purpose  : Combinational round-robin pick. Scans last+1 .. last+4 (mod 4)
//             and returns the first requesting index plus an any-request flag.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick_4
   import rr_sel_arbiter_4_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   winner,
   output logic               any
);

   // Scan from the farthest candidate back to the nearest so the nearest
   // requesting index after 'last' is the one that sticks.
   always_comb begin
      winner = '0;
      any    = |req;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[IDX_W'(last + IDX_W'(k))]) begin
            winner = IDX_W'(last + IDX_W'(k));
         end
      end
   end

endmodule : rr_pick_4
`default_nettype wire

// File: rtl/rr_sel_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_sel_arbiter_4
//  Purpose  : Round-robin arbiter producing select/enable for a 2x4 decoder.
//             Grants are held until done, request drop, or HOLD_MAX timeout,
//             and are always separated by at least one idle cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_sel_arbiter_4
   import rr_sel_arbiter_4_pkg::*;
#(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = $clog2(HOLD_MAX)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_en,
   output logic               timeout,
   output logic               busy
);

   localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_gnt_idx;
   logic [IDX_W-1:0]   w_gnt_idx_nxt;
   logic               r_gnt_en;
   logic               w_gnt_en_nxt;
   logic               r_timeout;
   logic               w_timeout_nxt;
   logic [CNT_W-1:0]   r_hold_cnt;
   logic [CNT_W-1:0]   w_hold_cnt_nxt;
   logic [IDX_W-1:0]   r_last;
   logic [IDX_W-1:0]   w_last_nxt;

   logic [IDX_W-1:0]   w_winner;
   logic               w_any;
   logic               w_rel_drop;
   logic               w_rel_tmo;
   logic               w_release;

   rr_pick_4 u_pick (
      .req    (req),
      .last   (r_last),
      .winner (w_winner),
      .any    (w_any)
   );

   assign w_rel_drop = ~req[r_gnt_idx];
   assign w_rel_tmo  = (r_hold_cnt == C_HOLD_LAST);
   assign w_release  = done | w_rel_drop | w_rel_tmo;

   // State and output registers; last resets to 3 so requester 0 wins first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_gnt_idx  <= '0;
         r_gnt_en   <= 1'b0;
         r_timeout  <= 1'b0;
         r_hold_cnt <= '0;
         r_last     <= 2'b11;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt_idx  <= w_gnt_idx_nxt;
         r_gnt_en   <= w_gnt_en_nxt;
         r_timeout  <= w_timeout_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
         r_last     <= w_last_nxt;
      end
   end

   // Next-state: IDLE grants on any request, GRANT returns to IDLE on release
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_any)     w_state_nxt = ST_GRANT;
         ST_GRANT: if (w_release) w_state_nxt = ST_IDLE;
         default:                 w_state_nxt = ST_IDLE;
      endcase
   end

   // Next output values; timeout only flags a release caused by the counter alone
   always_comb begin
      w_gnt_idx_nxt  = r_gnt_idx;
      w_gnt_en_nxt   = r_gnt_en;
      w_timeout_nxt  = 1'b0;
      w_hold_cnt_nxt = r_hold_cnt;
      w_last_nxt     = r_last;
      case (r_state)
         ST_IDLE: begin
            w_hold_cnt_nxt = '0;
            if (w_any) begin
               w_gnt_idx_nxt = w_winner;
               w_gnt_en_nxt  = 1'b1;
               w_last_nxt    = w_winner;
            end else begin
               w_gnt_en_nxt  = 1'b0;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               w_gnt_en_nxt   = 1'b0;
               w_hold_cnt_nxt = '0;
               w_timeout_nxt  = w_rel_tmo & ~done & ~w_rel_drop;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_gnt_en_nxt   = 1'b0;
            w_hold_cnt_nxt = '0;
         end
      endcase
   end

   assign gnt_idx = r_gnt_idx;
   assign gnt_en  = r_gnt_en;
   assign timeout = r_timeout;
   assign busy    = r_gnt_en;

endmodule : rr_sel_arbiter_4
`default_nettype wire

// File: tb/tb_rr_sel_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_sel_arbiter_4
//  Purpose  : Self-checking bench for rr_sel_arbiter_4 with a behavioural
//             grant model, directed scenarios and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_sel_arbiter_4;

   localparam int HOLD_MAX = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [1:0] gnt_idx;
   logic       gnt_en;
   logic       timeout;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: who owns the resource, how long, and who went last
   bit m_active;
   bit m_tmo;
   int m_owner;
   int m_last;
   int m_len;

   always #5 clk = ~clk;

   rr_sel_arbiter_4 #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .gnt_idx (gnt_idx),
      .gnt_en  (gnt_en),
      .timeout (timeout),
      .busy    (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_active = 1'b0;
      m_tmo    = 1'b0;
      m_owner  = 0;
      m_last   = 3;
      m_len    = 0;
   endfunction

   // One clock edge of the arbitration rules, using the inputs seen at that edge
   function automatic void model_step(input logic [3:0] r, input logic d);
      bit found;
      bit rel_done, rel_drop, rel_tmo;
      if (!m_active) begin
         m_tmo = 1'b0;
         found = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (!found && r[c]) begin
               found   = 1'b1;
               m_owner = c;
            end
         end
         if (found) begin
            m_active = 1'b1;
            m_last   = m_owner;
            m_len    = 1;
         end
      end else begin
         rel_done = d;
         rel_drop = !r[m_owner];
         rel_tmo  = (m_len == HOLD_MAX);
         if (rel_done || rel_drop || rel_tmo) begin
            m_active = 1'b0;
            m_tmo    = rel_tmo && !rel_done && !rel_drop;
            m_len    = 0;
         end else begin
            m_len++;
            m_tmo = 1'b0;
         end
      end
   endfunction

   task automatic compare_model(input string tag);
      check({tag, "/gnt_en"},  gnt_en,  m_active);
      check({tag, "/gnt_idx"}, gnt_idx, m_owner);
      check({tag, "/timeout"}, timeout, m_tmo);
      check({tag, "/busy"},    busy,    m_active);
   endtask

   task automatic step(input logic [3:0] r, input logic d, input string tag);
      req  = r;
      done = d;
      @(posedge clk);
      model_step(r, d);
      #1;
      compare_model(tag);
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = '0;
      done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      check("rst/gnt_en",  gnt_en,  0);
      check("rst/gnt_idx", gnt_idx, 0);
      check("rst/timeout", timeout, 0);
      check("rst/busy",    busy,    0);
      rst = 1'b0;
   endtask

   initial begin
      int hi;
      logic [3:0] rr;

      do_reset();

      // Single request: one-cycle latency, done releases without timeout
      step(4'b0100, 1'b0, "single");
      check("single_en",  gnt_en,  1);
      check("single_idx", gnt_idx, 2);
      step(4'b0100, 1'b1, "single_done");
      check("single_rel_en",  gnt_en,  0);
      check("single_rel_tmo", timeout, 0);
      step(4'b0000, 1'b0, "idle");

      // Rotation with all requesting: 0,1,2,3,0 with a gap between each
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b0, "rot_gnt");
         check("rot_idx", gnt_idx, i % 4);
         step(4'b1111, 1'b1, "rot_rel");
         check("rot_gap", gnt_en, 0);
      end

      // Wrap-around: after granting 3, requester 1 beats 3
      step(4'b1000, 1'b0, "wrap_g3");
      check("wrap_g3_idx", gnt_idx, 3);
      step(4'b1000, 1'b1, "wrap_rel");
      step(4'b1010, 1'b0, "wrap");
      check("wrap_idx", gnt_idx, 1);
      step(4'b1010, 1'b1, "wrap_rel2");

      // Timeout: held exactly HOLD_MAX cycles, one idle, then re-grant
      step(4'b0001, 1'b0, "tmo_gnt");
      hi = 0;
      for (int i = 0; i < 20 && gnt_en; i++) begin
         hi++;
         step(4'b0001, 1'b0, "tmo_hold");
      end
      check("tmo_len", hi, HOLD_MAX);
      check("tmo_pulse", timeout, 1);
      step(4'b0001, 1'b0, "tmo_regnt");
      check("tmo_regnt_en",  gnt_en,  1);
      check("tmo_regnt_idx", gnt_idx, 0);
      check("tmo_pulse_end", timeout, 0);
      step(4'b0001, 1'b1, "tmo_rel");

      // Request drop releases without timeout
      step(4'b0100, 1'b0, "drop_gnt");
      check("drop_idx", gnt_idx, 2);
      step(4'b0000, 1'b0, "drop");
      check("drop_en",  gnt_en,  0);
      check("drop_tmo", timeout, 0);

      // done coinciding with the timeout edge suppresses the pulse
      step(4'b0100, 1'b0, "sim_gnt");
      for (int i = 0; i < HOLD_MAX - 1; i++) step(4'b0100, 1'b0, "sim_hold");
      step(4'b0100, 1'b1, "sim_rel");
      check("sim_en",  gnt_en,  0);
      check("sim_tmo", timeout, 0);

      // Asynchronous reset in the middle of a grant
      step(4'b0010, 1'b0, "ar_gnt");
      check("ar_gnt_idx", gnt_idx, 1);
      #2;
      rst = 1'b1;
      #1;
      check("ar_en",   gnt_en,  0);
      check("ar_idx",  gnt_idx, 0);
      check("ar_busy", busy,    0);
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
      step(4'b0011, 1'b0, "ar_after");
      check("ar_after_idx", gnt_idx, 0);

      // Randomized traffic with sticky request patterns so timeouts occur
      rr = 4'b0000;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 4) == 0) rr = 4'($urandom_range(0, 15));
         step(rr, ($urandom_range(0, 6) == 0), "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule : tb_rr_sel_arbiter_4
`default_nettype wire
